br4_mul: RTL and testbench
==========================

Name: br4_mul

Overview:
- Parametrised sequential radix-4 Booth multiplier for the ALU datapath.
- Operands arrive one after the other over the shared `inbus`. The double-width product leaves over `outbus` in two consecutive words, low word first.
- Successor to the radix-2 multiply unit. New: configurable width, selectable signed/unsigned mode, and half the iteration count (two multiplier bits per step).

Parameters:
- W, 64, operand/bus width in bits; even, >= 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_b  input  1  reset; asynchronous, active-low.
- bgn  input  1  start request; sampled only in IDLE.
- sgn  input  1  1 = signed (two's complement), 0 = unsigned; sampled together with bgn.
- inbus  input  W  operand bus; sampled only in LOAD_M and LOAD_Q, may be Z otherwise.
- stop  output  1  one-cycle completion pulse.
- outbus  output  W  product word during OUT_LO/OUT_HI; 0 otherwise.

Behaviour:
- Reset (rst_b=0, any time, asynchronous):
  - state = IDLE.
  - stop = 0, outbus = 0.
  - all data registers and the iteration counter = 0.
- Reset mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE -> LOAD_M -> LOAD_Q -> CALC -> OUT_LO -> OUT_HI -> DONE -> IDLE.
- IDLE:
  - if bgn=1 at the edge: latch sgn into the mode register, go to LOAD_M.
  - else stay in IDLE.
- LOAD_M: capture inbus as multiplicand M; go to LOAD_Q.
- LOAD_Q:
  - capture inbus as multiplier Q.
  - clear accumulator A and the q(-1) bit.
  - load the counter with N = W/2 (signed) or W/2+1 (unsigned).
  - go to CALC.
- Internal widths:
  - M is extended to W+2 bits: sign-extend if signed, zero-extend if unsigned.
  - A is W+2 bits.
  - Q is extended to W+2 bits the same way as M; the extension bits are used only in the unsigned extra step.
- CALC, one step per cycle:
  - decode {Q[1],Q[0],q(-1)}: 000/111 -> +0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - add the selected value into A modulo 2^(W+2).
  - arithmetic-shift {A,Q,q(-1)} right by 2.
  - decrement the counter; after N steps go to OUT_LO.
- Product: the low 2W bits of {A,Q} after N steps, aligned so that P[W-1:0] and P[2W-1:W] are the low and high words.
- OUT_LO: outbus = P[W-1:0], stop = 0.
- OUT_HI: outbus = P[2W-1:W], stop = 0.
- DONE: stop = 1, outbus = 0; next state IDLE.
- stop and outbus are decoded from registered state and data only; there is no combinational path from inputs.
- Latency, counting the cycle in which bgn is sampled as cycle 0:
  - signed: LOAD_M = 1, LOAD_Q = 2, CALC = 3..W/2+2, OUT_LO = W/2+3, OUT_HI = W/2+4, stop in cycle W/2+5 (37 for W=64).
  - unsigned: one cycle later throughout (stop in cycle 38 for W=64).
- Back-to-back: bgn held high restarts in the IDLE cycle right after DONE. Minimum one IDLE cycle between operations.
- bgn toggling outside IDLE is ignored. sgn is ignored outside the bgn sample.
- Full range is correct with no overflow inside the datapath: signed min*min, unsigned max*max, zero operands.

Optional Feature:
- Macro BR4_OVF_EN.
- Defined:
  - adds output port `ovf` (1 bit).
  - ovf = 1 during DONE when the product does not fit in W bits, i.e. P[2W-1:W] differs from the extension of P[W-1] (signed) or from zero (unsigned).
  - ovf = 0 in all other states and under reset.
- Undefined: no ovf port or logic; behaviour is otherwise identical.

Test Plan:
- Signed 1200 * 1000 (W=64, bgn high from reset, operands in cycles 1 and 2) -> OUT_LO 0x124F80, OUT_HI 0, stop in cycle 37 only; ovf=0.
- Signed -3 * 7 -> OUT_LO 0xFFFFFFFFFFFFFFEB, OUT_HI 0xFFFFFFFFFFFFFFFF; ovf=0.
- Signed 0x8000000000000000 * 0x8000000000000000 -> OUT_LO 0, OUT_HI 0x4000000000000000; ovf=1.
- Unsigned 0xFFFFFFFFFFFFFFFF * 0xFFFFFFFFFFFFFFFF -> OUT_LO 1, OUT_HI 0xFFFFFFFFFFFFFFFE, stop in cycle 38; ovf=1.
- Assert rst_b=0 for 10 ns during CALC step 5 -> stop=0 and outbus=0 immediately, state IDLE. Then 5 * 6 signed -> OUT_LO 30, OUT_HI 0.
- bgn=0 for 10 cycles with inbus toggling -> stays in IDLE, stop=0, outbus=0. Then bgn held high over two operations -> two stop pulses 38 cycles apart (signed).

Source files
------------

// File: rtl/br4_mul.sv
// br4_mul: sequential radix-4 Booth multiplier, W x W -> 2W, signed or unsigned.
// Operands arrive on inbus in two cycles; the product leaves on outbus as low word, then high word, then a stop pulse.
// Optional overflow flag: define BR4_OVF_EN to add the ovf output.
`timescale 1ns/1ps

module br4_mul #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         bgn,
  input  logic         sgn,
  input  logic [W-1:0] inbus,
  output logic         stop,
  output logic [W-1:0] outbus
`ifdef BR4_OVF_EN
  ,
  output logic         ovf
`endif
);

  // Two guard bits above the operand width. They keep +/-2M and the
  // unsigned extra step inside the accumulator without overflowing.
  localparam int XW = W + 2;
  localparam int CW = $clog2(W / 2 + 2);

  // Signed mode consumes W multiplier bits (W/2 digits). Unsigned mode also
  // consumes the two zero extension bits, which needs one more digit.
  localparam logic [CW-1:0] N_SGN = CW'(W / 2);
  localparam logic [CW-1:0] N_UNS = CW'(W / 2 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_M,
    S_LOAD_Q,
    S_CALC,
    S_OUT_LO,
    S_OUT_HI,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          mode;      // 1 = signed operation
  logic [XW-1:0] m_reg;     // extended multiplicand
  logic [XW-1:0] a_reg;     // accumulator
  logic [XW-1:0] q_reg;     // extended multiplier, low product bits shift in from the top
  logic          q_m1;      // Booth look-behind bit q(-1)
  logic [CW-1:0] cnt;       // remaining CALC steps

  logic [XW-1:0] m_x2;
  logic [XW-1:0] addend;
  logic [XW-1:0] sum;
  logic [XW-1:0] a_nxt;
  logic [XW-1:0] q_nxt;
  logic          q_m1_nxt;
  logic [2*W-1:0] prod;
  logic [W-1:0]  prod_lo;
  logic [W-1:0]  prod_hi;

  // Extend an operand to the internal width according to the mode.
  function automatic logic [XW-1:0] ext(input logic [W-1:0] v, input logic s);
    if (s) begin
      return {{2{v[W-1]}}, v};
    end
    return {2'b00, v};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; the step counter ends the CALC phase.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bgn) state_nxt = S_LOAD_M;
      S_LOAD_M: state_nxt = S_LOAD_Q;
      S_LOAD_Q: state_nxt = S_CALC;
      S_CALC:   if (cnt == CW'(1)) state_nxt = S_OUT_LO;
      S_OUT_LO: state_nxt = S_OUT_HI;
      S_OUT_HI: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // 2M fits in XW bits: signed M needs at most W+1 bits, unsigned at most W.
  assign m_x2 = {m_reg[XW-2:0], 1'b0};

  // Booth radix-4 digit select from {Q[1], Q[0], q(-1)}.
  always_comb begin
    addend = '0;
    case ({q_reg[1:0], q_m1})
      3'b001, 3'b010: addend = m_reg;
      3'b011:         addend = m_x2;
      3'b100:         addend = -m_x2;
      3'b101, 3'b110: addend = -m_reg;
      default:        addend = '0;
    endcase
  end

  // Add, then arithmetic shift of {A, Q, q(-1)} right by two.
  always_comb begin
    sum      = a_reg + addend;
    a_nxt    = {{2{sum[XW-1]}}, sum[XW-1:2]};
    q_nxt    = {sum[1:0], q_reg[XW-1:2]};
    q_m1_nxt = q_reg[1];
  end

  // Datapath registers: operand capture, accumulator init and Booth steps.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mode  <= 1'b0;
      m_reg <= '0;
      a_reg <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bgn) mode <= sgn;
        end
        S_LOAD_M: begin
          m_reg <= ext(inbus, mode);
        end
        S_LOAD_Q: begin
          q_reg <= ext(inbus, mode);
          a_reg <= '0;
          q_m1  <= 1'b0;
          cnt   <= mode ? N_SGN : N_UNS;
        end
        S_CALC: begin
          a_reg <= a_nxt;
          q_reg <= q_nxt;
          q_m1  <= q_m1_nxt;
          cnt   <= cnt - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Product alignment. After the unsigned extra step the product sits at the
  // bottom of {A, Q}. In signed mode one fewer shift has happened, so the
  // product sits two bits higher and the unused extension bits of Q remain
  // at the bottom.
  always_comb begin
    if (mode) begin
      prod = {a_reg[W-1:0], q_reg[XW-1:2]};
    end else begin
      prod = {a_reg[W-3:0], q_reg};
    end
    prod_lo = prod[W-1:0];
    prod_hi = prod[2*W-1:W];
  end

  // Output decode from registered state and data only.
  always_comb begin
    stop   = 1'b0;
    outbus = '0;
    case (state)
      S_OUT_LO: outbus = prod_lo;
      S_OUT_HI: outbus = prod_hi;
      S_DONE:   stop   = 1'b1;
      default: begin
      end
    endcase
  end

`ifdef BR4_OVF_EN
  // Overflow: the high word is not just the extension of the low word.
  always_comb begin
    ovf = 1'b0;
    if (state == S_DONE) begin
      if (mode) begin
        ovf = (prod_hi != {W{prod_lo[W-1]}});
      end else begin
        ovf = (prod_hi != '0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_br4_mul.sv
// tb_br4_mul: directed vectors for br4_mul (W=64) with hand-computed products.
// Checks outbus/stop (and ovf when built with BR4_OVF_EN) every cycle of each operation.
// Also covers reset abort, idle with bgn low, and back-to-back operations.
`timescale 1ns/1ps

module tb_br4_mul;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_b;
  logic         bgn;
  logic         sgn;
  logic [W-1:0] inbus;
  logic         stop;
  logic [W-1:0] outbus;
`ifdef BR4_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit           s;
    logic [W-1:0] m;
    logic [W-1:0] q;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    bit           ov;
  } vec_t;

  vec_t vecs[13];
  vec_t v_after_rst;

  always #5 clk = ~clk;

  br4_mul #(.W(W)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .bgn    (bgn),
    .sgn    (sgn),
    .inbus  (inbus),
    .stop   (stop),
    .outbus (outbus)
`ifdef BR4_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  // Check every output in the current cycle against the expected values.
  task automatic chk_outs(input string tag, input int c, input logic [W-1:0] exp_out,
                          input bit exp_stop, input bit exp_ovf);
    chk($sformatf("%s outbus c%0d", tag, c), outbus, exp_out);
    chk($sformatf("%s stop c%0d", tag, c), W'(stop), W'(exp_stop));
`ifdef BR4_OVF_EN
    chk($sformatf("%s ovf c%0d", tag, c), W'(ovf), W'(exp_ovf));
`else
    if (exp_ovf && 1'b0) n_cmp = n_cmp + 0;
`endif
  endtask

  // One operation. Called right after a falling edge while the DUT is idle;
  // that cycle is cycle 0. Returns right after the falling edge of the idle
  // cycle following the stop pulse.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    logic [W-1:0] exp_out;
    lat = v.s ? (W / 2 + 5) : (W / 2 + 6);
    bgn = 1'b1;
    sgn = v.s;
    inbus = rnd64();
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      exp_out = (c == lat - 2) ? v.lo : (c == lat - 1) ? v.hi : '0;
      chk_outs(tag, c, exp_out, (c == lat), (c == lat) ? v.ov : 1'b0);
      bgn = 1'b0;
      sgn = 1'($urandom());
      inbus = (c == 1) ? v.m : (c == 2) ? v.q : rnd64();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    //            s   multiplicand             multiplier               low word                 high word                ovf
    vecs[0]  = '{1'b1, 64'd1200,               64'd1000,               64'h0000_0000_0012_4F80, 64'h0,                   1'b0};
    vecs[1]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,                  64'hFFFF_FFFF_FFFF_FFEB, ONES,                    1'b0};
    vecs[2]  = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0,                  64'h4000_0000_0000_0000, 1'b1};
    vecs[3]  = '{1'b0, ONES,                    ONES,                    64'h1,                  64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    vecs[4]  = '{1'b0, 64'h0,                   ONES,                    64'h0,                  64'h0,                   1'b0};
    vecs[5]  = '{1'b1, ONES,                    ONES,                    64'h1,                  64'h0,                   1'b0};
    vecs[6]  = '{1'b0, 64'h8000_0000_0000_0000, 64'd2,                   64'h0,                  64'h1,                   1'b1};
    vecs[7]  = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, ONES,                    64'h8000_0000_0000_0001, ONES,                   1'b0};
    vecs[8]  = '{1'b0, ONES,                    64'd1,                   ONES,                   64'h0,                   1'b0};
    vecs[9]  = '{1'b1, ONES,                    64'd1,                   ONES,                   ONES,                    1'b0};
    vecs[10] = '{1'b1, 64'h4000_0000_0000_0000, 64'd2,                   64'h8000_0000_0000_0000, 64'h0,                  1'b1};
    vecs[11] = '{1'b0, ONES,                    64'd2,                   64'hFFFF_FFFF_FFFF_FFFE, 64'h1,                  1'b1};
    vecs[12] = '{1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b1};
    v_after_rst = '{1'b1, 64'd5, 64'd6, 64'd30, 64'h0, 1'b0};

    // Reset with bgn already high; the first operation starts on release.
    rst_b = 1'b0;
    bgn   = 1'b1;
    sgn   = 1'b1;
    inbus = '0;
    repeat (2) @(negedge clk);
    chk_outs("reset", 0, '0, 1'b0, 1'b0);
    rst_b = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during CALC step 5 (cycle 7) must abort without any output.
    bgn = 1'b1;
    sgn = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      bgn = 1'b0;
      inbus = (c == 1) ? 64'd123456789 : (c == 2) ? 64'd987654321 : rnd64();
    end
    rst_b = 1'b0;
    #1;
    chk_outs("abort in reset", 7, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      chk_outs("after abort", c, '0, 1'b0, 1'b0);
      inbus = rnd64();
    end
    run_vec(v_after_rst, "after reset 5x6");

    // bgn low with a busy inbus: nothing must start.
    for (int c = 0; c < 10; c++) begin
      bgn = 1'b0;
      sgn = 1'($urandom());
      inbus = rnd64();
      @(negedge clk);
      chk_outs("idle", c, '0, 1'b0, 1'b0);
    end

    // bgn held high: 7*9 then -2*5 back to back, stops at 37 and 75.
    bgn = 1'b1;
    sgn = 1'b1;
    inbus = rnd64();
    for (int c = 1; c <= 76; c++) begin
      logic [W-1:0] exp_out;
      @(negedge clk);
      case (c)
        35:      exp_out = 64'd63;
        36:      exp_out = 64'h0;
        73:      exp_out = 64'hFFFF_FFFF_FFFF_FFF6;
        74:      exp_out = ONES;
        default: exp_out = '0;
      endcase
      chk_outs("b2b", c, exp_out, (c == 37) || (c == 75), 1'b0);
      if (c == 75) bgn = 1'b0;
      case (c)
        1:       inbus = 64'd7;
        2:       inbus = 64'd9;
        39:      inbus = 64'hFFFF_FFFF_FFFF_FFFE;
        40:      inbus = 64'd5;
        default: inbus = rnd64();
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
